ret_addr_stack: RTL
===================

// Module: ret_addr_stack
// PURPOSE
//  Return-address stack for the multicycle processor's subroutine-call extension.
//  - On CALL, the control FSM pushes the incremented PC (PC+1 mod 256) as the return address.
//  - On RET, it pops that address back into the PC mux.
//  - This block is the consumer end of the PC-increment path: the push side stores incremented PCs, the pop side reads them back.
// PARAMETERS
//  ADDR_W   8   width of a stored address (PC width)
//  DEPTH    8   number of entries; power of two, >= 2
//  PTR_W    3   log2(DEPTH); sizes internal pointers
// PORTS
//  clock      in   1       rising-edge clock
//  reset_n    in   1       asynchronous, active-low reset
//  clear      in   1       synchronous flush; highest priority after reset
//  push       in   1       store push_addr this cycle
//  push_addr  in   ADDR_W  return address; already PC+1 mod 256
//  pop        in   1       remove the top entry this cycle
//  pop_addr   out  ADDR_W  registered popped address
//  pop_valid  out  1       1-cycle pulse; pop_addr was updated by a successful pop
//  count      out  PTR_W+1 number of valid entries, 0..DEPTH
//  empty      out  1       count == 0
//  full       out  1       count == DEPTH
//  overflow   out  1       sticky; a push occurred while full
//  underflow  out  1       sticky; a pop occurred while empty without a push
// BEHAVIOUR
//  Reset (reset_n=0, asynchronous):
//   - pop_addr=0, pop_valid=0, count=0, empty=1, full=0, overflow=0, underflow=0.
//   - State = S_EMPTY. Storage array contents are don't-care.
//  State FSM (S_EMPTY, S_PART, S_FULL) mirrors count; empty and full decode from the state.
//  clear=1: same as reset except synchronous; push and pop that cycle are ignored.
//  Storage is circular: top pointer tp increments mod DEPTH on push and decrements mod DEPTH on pop.
//  Pop latency:
//   - pop_addr and pop_valid are registered; valid the cycle after pop is sampled.
//   - pop_addr holds its value until the next successful pop.
//  Per-cycle cases (push/pop):
//   - 1/0, not full: write mem[tp+1]; tp++; count++.
//   - 1/0, full: wrap. Overwrite the oldest entry (mem[tp+1]); tp++; count stays DEPTH; overflow<=1.
//   - 0/1, not empty: pop_addr<=mem[tp]; pop_valid<=1; tp--; count--.
//   - 0/1, empty: pop_addr unchanged; pop_valid<=0; underflow<=1.
//   - 1/1, not empty: pop_addr<=mem[tp]; mem[tp]<=push_addr (replace top); count unchanged; pop_valid<=1.
//   - 1/1, empty: bypass. pop_addr<=push_addr; pop_valid<=1; count stays 0; no underflow.
//   - 0/0: only pop_valid<=0.
//  Transitions:
//   - S_EMPTY->S_PART on net push.
//   - S_PART->S_FULL when count reaches DEPTH.
//   - S_PART->S_EMPTY when count reaches 0.
//   - S_FULL->S_PART on net pop.
//   - S_FULL stays on push (overwrite).
//  Arithmetic: pointers wrap mod DEPTH. count never exceeds DEPTH or drops below 0. Addresses are stored verbatim, with no arithmetic on them.
//  Sticky flags: cleared only by reset_n or clear.
// STRUCTURE
//  Shared package (proc_defs): ADDR_W, the RAS state encodings S_EMPTY=2'b00, S_PART=2'b01, S_FULL=2'b10, and RAS_DEPTH.
//  One sub-module: ras_mem, DEPTH x ADDR_W register file.
//   - One synchronous write port; one asynchronous read port at tp.
//   - Not reset.
//  Top level holds the FSM, the pointer and count logic, and the output registers.
// TESTING
//  1. Reset mid-stream: push 3 entries, assert reset_n=0 between clock edges -> outputs go to reset values immediately; pop then gives underflow=1, pop_valid=0.
//  2. LIFO order: push 0x10, 0x20, 0x30, then pop x3 -> pop_addr=0x30, 0x20, 0x10 on consecutive cycles with pop_valid=1; empty=1 after the third pop.
//  3. Wrap at 0xFF: push 0xFF then 0x00 (PC+1 wrapped) -> pops return 0x00 then 0xFF exactly.
//  4. Overflow: push 0x01..0x09 (DEPTH=8) -> full=1, overflow=1, count=8; popping 8 returns 0x09..0x02; a 9th pop sets underflow=1.
//  5. Simultaneous ops:
//   - push 0xA0, then push 0xB0 and pop together -> pop_addr=0xA0, count=1; next pop returns 0xB0.
//   - On empty, push 0xC0 and pop together -> pop_addr=0xC0, count=0, no underflow.
//  6. clear with push=1 while full -> count=0, overflow=0, underflow=0; the push is dropped.

Source files
------------

// File: rtl/proc_defs.sv
// Shared processor definitions: PC width, return-address-stack depth and
// the RAS fill-state encodings.
package proc_defs;

  localparam int ADDR_W    = 8;
  localparam int RAS_DEPTH = 8;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_PART  = 2'b01,
    S_FULL  = 2'b10
  } ras_state_t;

endpackage

// File: rtl/ras_mem.sv
// Return-address storage: DEPTH x ADDR_W register file with one synchronous
// write port and one asynchronous read port. Contents are not reset.
module ras_mem #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clock,
  input  logic              we,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [ADDR_W-1:0] rd_data
);

  logic [ADDR_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack for subroutine CALL/RET: circular LIFO of incremented
// PCs with registered pop output, fill-state FSM and sticky error flags.
module ret_addr_stack #(
  parameter int ADDR_W = proc_defs::ADDR_W,
  parameter int DEPTH  = proc_defs::RAS_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic [ADDR_W-1:0] pop_addr,
  output logic              pop_valid,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  import proc_defs::*;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  ras_state_t        state, next_state;
  logic [PTR_W-1:0]  tp, next_tp;
  logic [PTR_W:0]    next_count;
  logic [ADDR_W-1:0] next_pop_addr;
  logic              next_pop_valid;
  logic              set_ovf, set_udf;
  logic              mem_we;
  logic [PTR_W-1:0]  mem_wr_addr;
  logic [ADDR_W-1:0] rd_data;
  logic              is_empty, is_full;

  assign is_empty = (state == S_EMPTY);
  assign is_full  = (state == S_FULL);
  assign empty    = is_empty;
  assign full     = is_full;

  ras_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clock   (clock),
    .we      (mem_we),
    .wr_addr (mem_wr_addr),
    .wr_data (push_addr),
    .rd_addr (tp),
    .rd_data (rd_data)
  );

  // A push while full wraps onto the oldest slot; push+pop replaces the top
  // in place, and on an empty stack bypasses the address straight out.
  always_comb begin
    next_tp        = tp;
    next_count     = count;
    next_pop_addr  = pop_addr;
    next_pop_valid = 1'b0;
    set_ovf        = 1'b0;
    set_udf        = 1'b0;
    mem_we         = 1'b0;
    mem_wr_addr    = tp;
    case ({push, pop})
      2'b10: begin
        mem_we      = ~clear;
        mem_wr_addr = tp + PTR_W'(1);
        next_tp     = tp + PTR_W'(1);
        if (is_full) set_ovf = 1'b1;
        else         next_count = count + (PTR_W + 1)'(1);
      end
      2'b01: begin
        if (is_empty) begin
          set_udf = 1'b1;
        end else begin
          next_pop_addr  = rd_data;
          next_pop_valid = 1'b1;
          next_tp        = tp - PTR_W'(1);
          next_count     = count - (PTR_W + 1)'(1);
        end
      end
      2'b11: begin
        next_pop_valid = 1'b1;
        if (is_empty) begin
          next_pop_addr = push_addr;
        end else begin
          next_pop_addr = rd_data;
          mem_we        = ~clear;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_EMPTY: if (next_count != '0) next_state = S_PART;
      S_PART: begin
        if (next_count == FULL_COUNT) next_state = S_FULL;
        else if (next_count == '0)    next_state = S_EMPTY;
      end
      S_FULL:  if (next_count != FULL_COUNT) next_state = S_PART;
      default: next_state = S_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_EMPTY;
      tp        <= '0;
      count     <= '0;
      pop_addr  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      state     <= S_EMPTY;
      tp        <= '0;
      count     <= '0;
      pop_addr  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= next_state;
      tp        <= next_tp;
      count     <= next_count;
      pop_addr  <= next_pop_addr;
      pop_valid <= next_pop_valid;
      if (set_ovf) overflow  <= 1'b1;
      if (set_udf) underflow <= 1'b1;
    end
  end

endmodule
